// File: rtl/spi_slave.sv
// Memory-mapped SPI target. An external master clocks 8-bit mode-0 frames
// (MSB first) in and out through single-byte TX/RX buffers. sclk, cs_n and
// mosi are asynchronous and are oversampled on clk, so f_sclk must stay at or
// below f_clk/8.
module spi_slave #(
  parameter logic [31:0] SPIS_BASE_ADDR = 32'h40006000,
  parameter int unsigned SYNC_STAGES    = 2  // at least 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic        mem_we,
  input  logic        mem_re,
  output logic [31:0] mem_rdata,
  input  logic        spis_sclk,
  input  logic        spis_cs_n,
  input  logic        spis_mosi,
  output logic        spis_miso,
  output logic        spis_miso_oe,
  output logic        irq
);

  typedef enum logic [0:0] {StIdle, StActive} state_e;

  state_e state_q, state_d;

  logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
  logic sclk_prev_q, cs_prev_q;
  logic sclk_s, cs_s, mosi_s;
  logic sclk_rise, sclk_fall, cs_fall, cs_rise;

  logic [7:0] tx_buf_q, tx_buf_d;
  logic       tx_full_q, tx_full_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       overrun_q, overrun_d;
  logic       underrun_q, underrun_d;
  logic [2:0] ctrl_q, ctrl_d;
  logic [7:0] shift_tx_q, shift_tx_d;
  logic [7:0] shift_rx_q, shift_rx_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic       reload_q, reload_d;  // byte done, reload shift_tx on next sclk fall
  logic       fill_q, fill_d;      // 0xFF filler loaded, underrun once it is clocked
  logic       mem_re_q;
  logic       irq_q, irq_d;

  logic       en, rx_ie, tx_ie;
  logic       frame_start, frame_end, bit_rise, bit_fall, busy;
  logic       hit, rd_rx, wr_tx, wr_status, wr_ctrl;
  logic [1:0] off;
  logic [7:0] rx_byte;
  logic       unused_bits;

  assign en    = ctrl_q[0];
  assign rx_ie = ctrl_q[1];
  assign tx_ie = ctrl_q[2];

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign cs_fall   = ~cs_s & cs_prev_q;
  assign cs_rise   = cs_s & ~cs_prev_q;

  assign hit       = (mem_addr[31:4] == SPIS_BASE_ADDR[31:4]);
  assign off       = mem_addr[3:2];
  // Read side effects only on the first cycle of a read burst.
  assign rd_rx     = mem_re & ~mem_re_q & hit & (off == 2'd1);
  assign wr_tx     = mem_we & hit & (off == 2'd0);
  assign wr_status = mem_we & hit & (off == 2'd2);
  assign wr_ctrl   = mem_we & hit & (off == 2'd3);
  assign rx_byte   = {shift_rx_q[6:0], mosi_s};
  assign irq       = irq_q;

  assign unused_bits = ^{mem_addr[1:0], mem_wdata[31:8]};

  // Synchronizers plus one extra sample for edge detection; preset to bus idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b1;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spis_sclk};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spis_cs_n};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spis_mosi};
      sclk_prev_q <= sclk_s;
      cs_prev_q   <= cs_s;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: frames start on a cs_n fall, end on cs_n rise or disable.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (en && cs_fall) state_d = StActive;
      StActive: if (!en || cs_rise) state_d = StIdle;
    endcase
  end

  // FSM outputs: engine strobes and the MISO pad.
  always_comb begin
    frame_start  = 1'b0;
    frame_end    = 1'b0;
    bit_rise     = 1'b0;
    bit_fall     = 1'b0;
    busy         = 1'b0;
    spis_miso    = 1'b1;
    spis_miso_oe = 1'b0;
    unique case (state_q)
      StIdle: frame_start = en & cs_fall;
      StActive: begin
        busy         = 1'b1;
        spis_miso    = shift_tx_q[7];
        spis_miso_oe = 1'b1;
        if (!en || cs_rise) begin
          frame_end = 1'b1;
        end else begin
          bit_rise = sclk_rise;
          bit_fall = sclk_fall;
        end
      end
    endcase
  end

  // Register and shift-engine next state. Order encodes collision priority:
  // bus clears first, engine sets next, TXDATA write last.
  always_comb begin
    tx_buf_d   = tx_buf_q;
    tx_full_d  = tx_full_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    overrun_d  = overrun_q;
    underrun_d = underrun_q;
    ctrl_d     = ctrl_q;
    shift_tx_d = shift_tx_q;
    shift_rx_d = shift_rx_q;
    bit_cnt_d  = bit_cnt_q;
    reload_d   = reload_q;
    fill_d     = fill_q;

    if (rd_rx) rx_valid_d = 1'b0;
    if (wr_status) begin
      if (mem_wdata[2]) overrun_d = 1'b0;
      if (mem_wdata[4]) underrun_d = 1'b0;
    end

    if (frame_start) begin
      bit_cnt_d  = '0;
      shift_rx_d = '0;
      reload_d   = 1'b0;
      fill_d     = 1'b0;
      if (tx_full_q) begin
        shift_tx_d = tx_buf_q;
        tx_full_d  = 1'b0;
      end else begin
        shift_tx_d = 8'hFF;
        underrun_d = 1'b1;
      end
    end

    if (frame_end) begin
      bit_cnt_d  = '0;
      shift_rx_d = '0;
      reload_d   = 1'b0;
      fill_d     = 1'b0;
    end

    if (bit_rise) begin
      shift_rx_d = rx_byte;
      // A reloaded 0xFF filler only counts as underrun once the master clocks
      // it, so the trailing sclk fall of a frame's last byte raises nothing.
      if (fill_q) begin
        underrun_d = 1'b1;
        fill_d     = 1'b0;
      end
      if (bit_cnt_q == 3'd7) begin
        bit_cnt_d = '0;
        reload_d  = 1'b1;
        // rx_valid_d already reflects a same-cycle RXDATA read.
        if (!rx_valid_d) begin
          rx_data_d  = rx_byte;
          rx_valid_d = 1'b1;
        end else begin
          overrun_d = 1'b1;
        end
      end else begin
        bit_cnt_d = bit_cnt_q + 3'd1;
      end
    end

    if (bit_fall) begin
      if (reload_q) begin
        reload_d = 1'b0;
        if (tx_full_q) begin
          shift_tx_d = tx_buf_q;
          tx_full_d  = 1'b0;
        end else begin
          shift_tx_d = 8'hFF;
          fill_d     = 1'b1;
        end
      end else if (bit_cnt_q != 3'd0) begin
        shift_tx_d = {shift_tx_q[6:0], 1'b0};
      end
    end

    if (wr_tx) begin
      tx_buf_d  = mem_wdata[7:0];
      tx_full_d = 1'b1;
    end
    if (wr_ctrl) ctrl_d = mem_wdata[2:0];
  end

  // Interrupt level, registered from the current flags.
  always_comb begin
    irq_d = (rx_ie & rx_valid_q) | (tx_ie & ~tx_full_q & busy);
  end

  // Register and engine state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_buf_q   <= '0;
      tx_full_q  <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      overrun_q  <= 1'b0;
      underrun_q <= 1'b0;
      ctrl_q     <= '0;
      shift_tx_q <= '0;
      shift_rx_q <= '0;
      bit_cnt_q  <= '0;
      reload_q   <= 1'b0;
      fill_q     <= 1'b0;
      mem_re_q   <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      tx_buf_q   <= tx_buf_d;
      tx_full_q  <= tx_full_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      overrun_q  <= overrun_d;
      underrun_q <= underrun_d;
      ctrl_q     <= ctrl_d;
      shift_tx_q <= shift_tx_d;
      shift_rx_q <= shift_rx_d;
      bit_cnt_q  <= bit_cnt_d;
      reload_q   <= reload_d;
      fill_q     <= fill_d;
      mem_re_q   <= mem_re;
      irq_q      <= irq_d;
    end
  end

  // Read mux, pure decode of the address.
  always_comb begin
    mem_rdata = '0;
    if (hit) begin
      unique case (off)
        2'd1:    mem_rdata = {24'b0, rx_data_q};
        2'd2:    mem_rdata = {27'b0, underrun_q, busy, overrun_q, tx_full_q, rx_valid_q};
        2'd3:    mem_rdata = {29'b0, ctrl_q};
        default: mem_rdata = '0;
      endcase
    end
  end

endmodule

// File: doc/spi_slave.md
Name: spi_slave

Overview:
- Memory-mapped SPI target (responder) peripheral. It is the far end of the SPI master protocol: an external SPI master clocks bytes in and out of the SoC.
- Sits on the core data bus beside the uart, gpio, timer, pwm, i2c and spi master peripherals. Its mem_rdata is muxed by mem_ctl.
- External sclk/cs_n/mosi are asynchronous and are oversampled on clk. Mode 0 only, MSB first, 8-bit frames, single-byte TX and RX buffers.

Parameters:
- SPIS_BASE_ADDR, 32'h40006000, base of the 16-byte register window.
- SYNC_STAGES, 2, synchronizer depth for sclk/cs_n/mosi (min 2).

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-high reset
- mem_addr  input  32  core data address
- mem_wdata  input  32  core write data
- mem_we  input  1  write strobe
- mem_re  input  1  read strobe
- mem_rdata  output  32  read data, combinational decode of mem_addr; 0 outside the window
- spis_sclk  input  1  external SPI clock (async)
- spis_cs_n  input  1  external chip select, active low (async)
- spis_mosi  input  1  external data in (async)
- spis_miso  output  1  data out
- spis_miso_oe  output  1  miso drive enable
- irq  output  1  interrupt, level

Behaviour:
- Reset: all flags 0, tx_buf=0, rx_data=0, ctrl=0, spis_miso=1, spis_miso_oe=0, irq=0, bit_cnt=0, shift reg=0, synchronizers preset to idle (sclk=0, cs_n=1).
- Register map (word offsets):
  - 0x0 TXDATA (W): write loads [7:0] into tx_buf and sets tx_full. A write while tx_full overwrites the buffer.
  - 0x4 RXDATA (R): returns {24'b0, rx_data}. Clears rx_valid.
  - 0x8 STATUS: [0] rx_valid, [1] tx_full, [2] overrun, [3] busy (cs active), [4] underrun. R returns the flags. W1C on bits 2 and 4.
  - 0xC CTRL (R/W): [0] en, [1] rx_ie, [2] tx_ie.
- Read side effects fire only on the first cycle of a read burst (mem_re & ~mem_re_q & address hit), so a multi-cycle mem_re clears rx_valid once.
- Edge detect: rise/fall pulses come from the last two synchronized samples. Requirement: f_sclk ≤ f_clk/8.
- The SPI engine is active only when en=1. When en=0, the engine holds idle, cs_n is ignored, and miso_oe=0.
- States:
  - IDLE → ACTIVE on a cs_n falling edge. On entry: bit_cnt=0.
    - If tx_full: load shift_tx=tx_buf and clear tx_full.
    - Else: load 8'hFF and set underrun.
    - Drive miso=shift_tx[7] and set miso_oe=1.
  - ACTIVE, sclk rise: shift_rx={shift_rx[6:0], mosi_sync}, then bit_cnt+1.
  - ACTIVE, sclk fall with bit_cnt≠0: shift_tx<<1, miso=new shift_tx[7].
  - ACTIVE, completion (bit_cnt reaches 8 on a rise):
    - If rx_valid=0: rx_data=byte, rx_valid=1.
    - Else: byte discarded, overrun=1, rx_data unchanged.
    - bit_cnt=0. Reload shift_tx from tx_buf (or FF plus underrun) on the next sclk fall, which supports back-to-back bytes within one cs.
  - ACTIVE → IDLE on a cs_n rising edge. Any partial byte is discarded with no flag. miso_oe=0, miso=1.
  - en cleared mid-transfer: same as a cs_n rising edge.
- Simultaneous events:
  - Bus RXDATA read on the same cycle as a byte completion: the completion wins. rx_valid stays 1 with the new data, and the old data is returned on this read.
  - TXDATA write on the same cycle as a shift load: the load takes the old tx_buf, then tx_buf takes the new value with tx_full=1.
  - W1C on the same cycle as a flag set: the set wins.
- irq = (rx_ie & rx_valid) | (tx_ie & ~tx_full & busy). Registered, so it lags the flag by 1 clk.
- Latency: rx_valid asserts within SYNC_STAGES+2 clk of the 8th sclk rise.

Test Plan:
- Reset and idle: assert rst async mid-cycle → all outputs and registers at reset values. Reading 0x8 returns 0, reading 0x100 returns 0.
- Single byte: write CTRL=1, TXDATA=0xA5. Master sends 0x3C at clk/8 → master receives 0xA5, RXDATA=0x3C, STATUS=0x0 after the read, tx_full cleared at cs fall.
- Back-to-back: TXDATA=0x11, cs low, master sends 0x01 then 0x02 with no refill → second MISO byte is 0xFF with underrun=1. rx_valid set, and since RXDATA was not read between bytes, overrun=1 and RXDATA=0x01.
- Abort: cs_n rises after 5 bits → rx_valid stays 0, bit_cnt reset. The next full byte 0x7E is received correctly.
- Collisions: RXDATA read on the cycle of a completion → rx_valid remains 1 and the next read returns the new byte. Writing STATUS=0x4 on the cycle overrun sets → overrun=1.
- Interrupts and enable: rx_ie=1 → irq rises 1 clk after rx_valid and falls after the RXDATA read. With en=0, cs activity leaves miso_oe=0 and flags unchanged.
